// File: rtl/seg7_scan_display_if.sv
// Load-side bus of seg7_scan_display: value/mode/blanking strobe, live dp enables, busy.
interface seg7_scan_display_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   din;
  logic                  mode;
  logic                  blank_lz;
  logic [DIGITS-1:0]     dp;
  logic                  busy;

  modport master (output load, din, mode, blank_lz, dp, input busy);
  modport slave  (input load, din, mode, blank_lz, dp, output busy);
endinterface

// File: rtl/seg7_scan_display.sv
// Multiplexed DIGITS-wide 7-segment driver, hex or decimal (sequential double-dabble).
// Optional SEG7_GHOST_BLANK_EN: select lines held inactive for the first 4 cycles of each slot.
module seg7_scan_display #(
  parameter int DIGITS         = 4,
  parameter int CLK_HZ         = 50000000,
  parameter int SLOT_HZ        = 1000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic               sysclk,
  input  logic               reset,
  seg7_scan_display_if.slave bus,
  output logic [7:0]         SEG,
  output logic [DIGITS-1:0]  SEG_S
);
  localparam int DIN_W    = 4 * DIGITS;
  localparam int BCD_W    = 4 * (DIGITS + 1);
  localparam int SLOT_CYC = CLK_HZ / SLOT_HZ;
  localparam int PW       = $clog2(SLOT_CYC);
  localparam int IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW       = $clog2(DIN_W);
  localparam logic [7:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              busy_q, busy_d;
  logic [CW-1:0]     step_q, step_d;
  logic [DIN_W-1:0]  bin_q, bin_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [DIN_W-1:0]  disp_q, disp_d;
  logic              ovf_q, ovf_d;
  logic              blank_q, blank_d;
  logic              blank_pend_q, blank_pend_d;
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] sel_q, sel_d;

  logic [BCD_W-1:0]  bcd_adj;
  logic [BCD_W-1:0]  bcd_shift;
  logic [DIGITS-1:0] lead_zero;
  logic [3:0]        nib;
  logic [6:0]        pat;
  logic [7:0]        lit;
  logic [7:0]        seg_drive;
  logic [DIGITS-1:0] onehot;
  logic [DIGITS-1:0] sel_drive;

  function automatic logic [6:0] font7(input logic [3:0] v);
    case (v)
      4'h0:    return 7'h3F;
      4'h1:    return 7'h06;
      4'h2:    return 7'h5B;
      4'h3:    return 7'h4F;
      4'h4:    return 7'h66;
      4'h5:    return 7'h6D;
      4'h6:    return 7'h7D;
      4'h7:    return 7'h07;
      4'h8:    return 7'h7F;
      4'h9:    return 7'h6F;
      4'hA:    return 7'h77;
      4'hB:    return 7'h7C;
      4'hC:    return 7'h39;
      4'hD:    return 7'h5E;
      4'hE:    return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  // Double-dabble: add 3 to every BCD digit >= 5 before the shift.
  for (genvar gi = 0; gi < DIGITS + 1; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                            : bcd_q[4*gi +: 4];
  end
  assign bcd_shift = (bcd_adj << 1) | {{(BCD_W-1){1'b0}}, bin_q[DIN_W-1]};

  // lead_zero[i]: digit i and every digit above it are zero.
  always_comb begin
    logic run;
    run       = 1'b1;
    lead_zero = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run          = run & (disp_q[4*i +: 4] == 4'd0);
      lead_zero[i] = run;
    end
  end

  always_comb begin
    nib = disp_q[{idx_q, 2'b00} +: 4];
    if (ovf_q)
      pat = 7'h40;
    else if (blank_q && lead_zero[idx_q] && (idx_q != '0))
      pat = 7'h00;
    else
      pat = font7(nib);
    lit       = {bus.dp[idx_q], pat};
    seg_drive = (SEG_ACTIVE_LOW != 0) ? ~lit : lit;
    onehot         = '0;
    onehot[idx_q]  = 1'b1;
    sel_drive = (SEL_ACTIVE_LOW != 0) ? ~onehot : onehot;
  end

  always_comb begin
    presc_d      = presc_q;
    idx_d        = idx_q;
    busy_d       = busy_q;
    step_d       = step_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    disp_d       = disp_q;
    ovf_d        = ovf_q;
    blank_d      = blank_q;
    blank_pend_d = blank_pend_q;
    seg_d        = seg_q;
    sel_d        = sel_q;

    if (presc_q == PW'(SLOT_CYC - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
    end

    // Outputs only move at slot start so display/dp changes never glitch mid-slot.
`ifdef SEG7_GHOST_BLANK_EN
    if (presc_q == '0) begin
      seg_d = seg_drive;
      sel_d = SEL_OFF;
    end else if (presc_q == PW'(4)) begin
      sel_d = sel_drive;
    end
`else
    if (presc_q == '0) begin
      seg_d = seg_drive;
      sel_d = sel_drive;
    end
`endif

    if (busy_q) begin
      bin_d  = bin_q << 1;
      bcd_d  = bcd_shift;
      step_d = step_q + 1'b1;
      if (step_q == CW'(DIN_W - 1)) begin
        busy_d  = 1'b0;
        disp_d  = bcd_shift[DIN_W-1:0];
        ovf_d   = (bcd_shift[BCD_W-1 -: 4] != 4'd0);
        blank_d = blank_pend_q;
      end
    end else if (bus.load) begin
      if (bus.mode) begin
        busy_d       = 1'b1;
        bin_d        = bus.din;
        bcd_d        = '0;
        step_d       = '0;
        blank_pend_d = bus.blank_lz;
      end else begin
        disp_d  = bus.din;
        ovf_d   = 1'b0;
        blank_d = bus.blank_lz;
      end
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      step_q       <= '0;
      bin_q        <= '0;
      bcd_q        <= '0;
      disp_q       <= '0;
      ovf_q        <= 1'b0;
      blank_q      <= 1'b0;
      blank_pend_q <= 1'b0;
      seg_q        <= SEG_OFF;
      sel_q        <= SEL_OFF;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      busy_q       <= busy_d;
      step_q       <= step_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      disp_q       <= disp_d;
      ovf_q        <= ovf_d;
      blank_q      <= blank_d;
      blank_pend_q <= blank_pend_d;
      seg_q        <= seg_d;
      sel_q        <= sel_d;
    end
  end

  assign bus.busy = busy_q;
  assign SEG      = seg_q;
  assign SEG_S    = sel_q;
endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: 4 digits, 10 cycles per slot, randomized loads.
module tb_seg7_scan_display;
  localparam int DIGITS = 4;
  localparam int SLOT   = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] seg;
  logic [3:0] seg_s;

  seg7_scan_display_if #(.DIGITS(DIGITS)) bus_if ();

  seg7_scan_display #(
    .DIGITS(DIGITS), .CLK_HZ(1000), .SLOT_HZ(100),
    .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
  ) dut (
    .sysclk(clk), .reset(reset_n), .bus(bus_if), .SEG(seg), .SEG_S(seg_s)
  );

  always #5 clk = ~clk;

  // Edges since reset release; slot k starts at the edge that makes e = 10k+1.
  int e;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) e <= 0;
    else          e <= e + 1;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  cur_exp;
  bit          cur_valid = 0;
  int unsigned m_val = 0;
  bit          m_dec = 0;
  bit          m_blk = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned pow10(input int k);
    int unsigned p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] font7(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // Reference: pins expected for digit idx of the displayed number.
  function automatic logic [7:0] model_seg(input int unsigned val, input bit dec, input bit blk,
                                           input bit dpb, input int idx);
    logic [6:0]  pat;
    int unsigned hi;
    int          digit;
    if (dec && val > 9999) begin
      pat = 7'h40;
    end else begin
      if (dec) begin
        hi    = val / pow10(idx);
        digit = int'(hi % 10);
      end else begin
        hi    = val >> (4 * idx);
        digit = int'(hi % 16);
      end
      if (blk && idx > 0 && hi == 0) pat = 7'h00;
      else                           pat = font7(digit);
    end
    return ~{dpb, pat};
  endfunction

  // Monitor: select checked every cycle from timing, SEG popped at each slot start.
  always @(negedge clk) begin
    int         pos;
    int         idx;
    logic [3:0] exp_sel;
    if (e == 0) begin
      check("rst_seg", seg, 8'hFF);
      check("rst_sel", seg_s, 4'hF);
      cur_valid = 0;
    end else begin
      pos     = (e - 1) % SLOT;
      idx     = ((e - 1) / SLOT) % DIGITS;
      exp_sel = ~(4'b0001 << idx);
`ifdef SEG7_GHOST_BLANK_EN
      if (pos < 4) exp_sel = 4'hF;
`endif
      check("sel", seg_s, exp_sel);
      if (pos == 0) begin
        if (exp_q.size() > 0) begin
          cur_exp   = exp_q.pop_front();
          cur_valid = 1;
        end else begin
          cur_valid = 0;
        end
      end
      if (cur_valid) check("seg", seg, cur_exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_window();
    int n;
    int base;
    int idx;
    n = 0;
    while (e % SLOT != 5 && n < 30) begin
      tick();
      n++;
    end
    if (e % SLOT != 5) begin
      n_vec++; n_bad++;
      $display("FAIL align_timeout: got e=%0d, expected mid-slot", e);
    end
    base = (e - 1) / SLOT;
    for (int j = 1; j <= DIGITS; j++) begin
      idx = (base + j) % DIGITS;
      exp_q.push_back(model_seg(m_val, m_dec, m_blk, bus_if.dp[idx], idx));
    end
    n = 0;
    while (exp_q.size() > 0 && n < 80) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) begin
      n_vec++; n_bad++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_load(input int unsigned val, input bit dec, input bit blk,
                         input int inject_at, input int reset_at);
    bus_if.din      = val[15:0];
    bus_if.mode     = dec;
    bus_if.blank_lz = blk;
    bus_if.load     = 1'b1;
    tick();
    bus_if.load = 1'b0;
    $display("load val=%0d dec=%0d blk=%0d dp=%b", val, dec, blk, bus_if.dp);
    if (!dec) begin
      check("hex_busy", bus_if.busy, 0);
      m_val = val; m_dec = 0; m_blk = blk;
      return;
    end
    for (int i = 0; i < 16; i++) begin
      if (i == reset_at) begin
        reset_n = 1'b0;
        #1;
        check("rstmid_busy", bus_if.busy, 0);
        check("rstmid_seg", seg, 8'hFF);
        check("rstmid_sel", seg_s, 4'hF);
        tick();
        reset_n = 1'b1;
        m_val = 0; m_dec = 0; m_blk = 0;
        return;
      end
      check("dec_busy", bus_if.busy, 1);
      bus_if.load = (i == inject_at);
      if (i == inject_at) begin
        bus_if.din  = 16'h0042;
        bus_if.mode = 1'b0;
      end
      tick();
    end
    bus_if.load = 1'b0;
    check("busy_fall", bus_if.busy, 0);
    m_val = val; m_dec = 1; m_blk = blk;
  endtask

  initial begin
    int unsigned v;
    int          r;
    bus_if.load     = 1'b0;
    bus_if.din      = '0;
    bus_if.mode     = 1'b0;
    bus_if.blank_lz = 1'b0;
    bus_if.dp       = '0;
    reset_n         = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", bus_if.busy, 0);
    reset_n = 1'b1;
    tick();
    check("first_seg", seg, 8'hC0);
    check("first_sel", seg_s, 4'hE);
    push_window();

    bus_if.dp = 4'b0100;
    do_load(32'h1A2F, 0, 0, -1, -1);
    push_window();

    bus_if.dp = 4'b0000;
    do_load(305, 1, 1, -1, -1);
    push_window();

    bus_if.dp = 4'b1001;
    do_load(12345, 1, 0, 3, -1);
    push_window();

    do_load(777, 1, 0, -1, 7);
    push_window();

    do_load($urandom_range(0, 9999), 1, 1, -1, -1);
    push_window();

    for (int it = 0; it < 12; it++) begin
      r = $urandom_range(0, 3);
      case (r)
        0:       v = $urandom_range(0, 9);
        1:       v = $urandom_range(0, 999);
        2:       v = $urandom_range(0, 65535);
        default: v = $urandom_range(10000, 65535);
      endcase
      bus_if.dp = 4'($urandom_range(0, 15));
      do_load(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, -1);
      push_window();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Parametrised successor to the fixed 4-digit dynamic 7-segment driver.
- Time-multiplexes DIGITS common-select digits from a packed value, in hex or in decimal.
- Decimal mode uses a sequential binary-to-BCD converter; also provides leading-zero blanking and overflow indication.
- Sits between the sensor/ADC readout blocks (e.g. the pcf8591 reader) and the board's SEG/SEL pins.

Parameters:
- DIGITS, 4: number of multiplexed digits, 1..8.
- CLK_HZ, 50000000: sysclk frequency in Hz.
- SLOT_HZ, 1000: digit-slot rate; each digit is held CLK_HZ/SLOT_HZ cycles, and CLK_HZ/SLOT_HZ must be at least 2.
- SEG_ACTIVE_LOW, 1: 1 means a lit segment drives 0.
- SEL_ACTIVE_LOW, 1: 1 means the selected digit drives 0.

Ports:
- sysclk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-low reset.
- load  in  1  single-cycle strobe; captures din, mode and blank_lz.
- din  in  4*DIGITS  value to display; hex nibbles, or unsigned binary in decimal mode.
- mode  in  1  0 = hex, 1 = decimal.
- blank_lz  in  1  1 = blank leading zero digits.
- dp  in  DIGITS  decimal-point enables, bit i = digit i; sampled live, not latched.
- busy  out  1  high while a decimal conversion runs.
- SEG  out  8  SEG[7] = dp, SEG[6:0] = g..a.
- SEG_S  out  DIGITS  one-hot digit select; bit 0 = rightmost digit.

Behaviour:
- Reset (reset=0, async):
  - SEG = all segments off (8'hFF if SEG_ACTIVE_LOW).
  - SEG_S = all inactive.
  - busy = 0; slot prescaler = 0; digit index = 0.
  - Display register = all zero, no overflow.
  - Reset asserted mid-conversion aborts it; busy clears immediately.
- Load:
  - Accepted only when busy = 0; load with busy = 1 is ignored.
  - Hex mode: display register = din at the cycle after load; busy stays 0.
  - Decimal mode: busy rises the cycle after load.
    - Double-dabble runs over DIN_W = 4*DIGITS bits, one shift per cycle, using DIGITS+1 BCD digits internally.
    - After exactly DIN_W cycles, busy falls and the display register updates in the same cycle.
    - Total latency from load to display update is DIN_W+1 cycles.
    - A load in the cycle busy falls is accepted (busy already 0 that cycle).
  - blank_lz is captured with din at load.
- Overflow (decimal only): if the extra top BCD digit is nonzero, every digit shows '-' (segment g only) and dp is still honoured. Example: DIGITS=4, din=16'd12345 displays "----".
- Scan:
  - Prescaler counts 0..CLK_HZ/SLOT_HZ-1.
  - On terminal count the digit index advances, wrapping from DIGITS-1 to 0.
  - SEG_S and SEG change together, registered, one cycle after the index changes.
  - Full refresh period = DIGITS*CLK_HZ/SLOT_HZ cycles.
- Font (hex): 0-9 and A b C d E F, standard patterns; '0' = segments a-f on, g off.
- Leading-zero blanking: when enabled, digit i is blank if it and all higher digits are 0. Digit 0 is never blanked. dp still shows on blank digits.
- Display changes take effect at the next slot boundary; mid-slot SEG glitches are not permitted.

Optional Feature:
- SEG7_GHOST_BLANK_EN defined:
  - SEG_S is held all-inactive for the first 4 cycles of every slot (requires CLK_HZ/SLOT_HZ > 8), suppressing ghosting.
  - SEG is updated at slot start as normal.
- Undefined: SEG_S is active for the whole slot.

Test Plan:
- Bench settings: CLK_HZ=1000, SLOT_HZ=100 (10 cycles/slot), DIGITS=4.
- Reset release, no load -> SEG=8'hFF, then digit 0 shows '0' (SEG=8'hC0), SEG_S cycles 1110, 1101, 1011, 0111 every 10 cycles.
- Hex load din=16'h1A2F, dp=4'b0100 -> digits F,2,A,1; SEG on digit 2 = 8'h08 ('A' with dp lit, active low).
- Decimal load din=16'd305, blank_lz=1 -> busy high exactly 16 cycles; display " 305" with digit 3 blank (SEG=8'hFF).
- Decimal load din=16'd12345 -> all digits show '-' (SEG=8'hBF); a second load issued while busy is ignored.
- Reset pulse at conversion cycle 7 -> busy=0 and outputs return to reset values immediately; the next load converts correctly.
- Build with SEG7_GHOST_BLANK_EN -> SEG_S=4'b1111 for cycles 0-3 of each slot, active for cycles 4-9.
